pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction fetch stage: owns the program counter, issues fetch requests to
// instruction memory, and presents fetched instructions to decode through the
// IF/ID register. A one-entry skid buffer absorbs an instruction that returns
// while decode is stalled, so no fetched word is ever lost or duplicated.
// Taken branches (and, optionally, jumps) from decode redirect the PC with a
// one-cycle latency and squash everything in flight.
//
// Configuration macro:
//   PC_FETCH_JUMP_EN  defined   -> jump/jump_target redirect the PC
//                     undefined -> jump/jump_target are accepted but ignored
//
// Parameters:
//   WIDTH       PC / address width in bits (>= 28)
//   RESET_ADDR  word-aligned PC value loaded on reset
//
// Ports:
//   clk                in   single clock, rising edge
//   reset              in   asynchronous active-high reset
//   stall              in   decode cannot accept; IF/ID holds
//   branch_taken       in   taken-branch redirect from decode
//   branch_imm         in   sign-extended word offset of the branch
//   redirect_pc_plus4  in   PC+4 of the redirecting instruction
//   jump               in   unconditional jump redirect
//   jump_target        in   instr[25:0] of the jump
//   imem_req           out  fetch request outstanding
//   imem_addr          out  fetch address (current PC)
//   imem_ready         in   imem_rdata valid for the outstanding request
//   imem_rdata         in   fetched instruction
//   instr_out          out  IF/ID instruction
//   pc_out             out  IF/ID PC
//   pc_plus4_out       out  IF/ID PC+4
//   valid_out          out  IF/ID valid
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_imm,
  input  logic [WIDTH-1:0] redirect_pc_plus4,
  input  logic             jump,
  input  logic [25:0]      jump_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4_out,
  output logic             valid_out
);

  // HOLD means the skid buffer is full and no request is issued.
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Address arithmetic always wraps modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] add_wrap(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return a + b;
  endfunction

  // Converts a signed word offset into a byte offset, dropping overflow bits.
  function automatic logic signed [WIDTH-1:0] word_to_byte(input logic signed [WIDTH-1:0] w);
    return w <<< 2;
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [31:0]      r_skid_instr;
  logic [WIDTH-1:0] r_skid_pc;
  logic [WIDTH-1:0] r_skid_pc4;
  logic [31:0]      r_ifid_instr;
  logic [WIDTH-1:0] r_ifid_pc;
  logic [WIDTH-1:0] r_ifid_pc4;
  logic             r_ifid_valid;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [31:0]      w_skid_instr_nxt;
  logic [WIDTH-1:0] w_skid_pc_nxt;
  logic [WIDTH-1:0] w_skid_pc4_nxt;
  logic [31:0]      w_ifid_instr_nxt;
  logic [WIDTH-1:0] w_ifid_pc_nxt;
  logic [WIDTH-1:0] w_ifid_pc4_nxt;
  logic             w_ifid_valid_nxt;
  logic             w_imem_req;

  logic [WIDTH-1:0]        w_pc_plus4;
  logic signed [WIDTH-1:0] w_branch_off;
  logic [WIDTH-1:0]        w_branch_tgt;
  logic                    w_redirect;
  logic [WIDTH-1:0]        w_target;

  assign w_pc_plus4   = add_wrap(r_pc, WIDTH'(4));
  assign w_branch_off = word_to_byte($signed(branch_imm));
  assign w_branch_tgt = add_wrap(redirect_pc_plus4, $unsigned(w_branch_off));

`ifdef PC_FETCH_JUMP_EN
  logic [WIDTH-1:0] w_jump_tgt;

  // Jump keeps the upper region bits of the redirecting instruction's PC+4.
  if (WIDTH > 28) begin : g_jump_region
    assign w_jump_tgt = {redirect_pc_plus4[WIDTH-1:28], jump_target, 2'b00};
  end else begin : g_jump_flat
    assign w_jump_tgt = {jump_target, 2'b00};
  end

  // Branch has priority when both redirects arrive together.
  assign w_redirect = branch_taken | jump;
  assign w_target   = branch_taken ? w_branch_tgt : w_jump_tgt;
`else
  // Jump inputs stay on the port list but drive nothing.
  logic w_unused_jump;
  assign w_unused_jump = ^{jump, jump_target};

  assign w_redirect = branch_taken;
  assign w_target   = w_branch_tgt;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc_nxt    = r_skid_pc;
    w_skid_pc4_nxt   = r_skid_pc4;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_pc4_nxt   = r_ifid_pc4;
    w_ifid_valid_nxt = r_ifid_valid;
    w_imem_req       = 1'b0;

    case (r_state)
      ST_FETCH: w_imem_req = 1'b1;
      default:  w_imem_req = 1'b0;
    endcase

    if (w_redirect) begin
      // Squash: the buffered word and any same-cycle return are dropped by
      // leaving HOLD and never loading them into IF/ID.
      w_pc_nxt         = w_target;
      w_ifid_valid_nxt = 1'b0;
      w_state_nxt      = ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_ready) begin
            w_pc_nxt = w_pc_plus4;
            if (stall) begin
              w_skid_instr_nxt = imem_rdata;
              w_skid_pc_nxt    = r_pc;
              w_skid_pc4_nxt   = w_pc_plus4;
              w_state_nxt      = ST_HOLD;
            end else begin
              w_ifid_instr_nxt = imem_rdata;
              w_ifid_pc_nxt    = r_pc;
              w_ifid_pc4_nxt   = w_pc_plus4;
              w_ifid_valid_nxt = 1'b1;
            end
          end else if (!stall) begin
            // Decode consumed the previous word and nothing arrived: bubble.
            w_ifid_valid_nxt = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            w_ifid_instr_nxt = r_skid_instr;
            w_ifid_pc_nxt    = r_skid_pc;
            w_ifid_pc4_nxt   = r_skid_pc4;
            w_ifid_valid_nxt = 1'b1;
            w_state_nxt      = ST_FETCH;
          end
        end
        default: w_state_nxt = ST_FETCH;
      endcase
    end
  end

  // Reset clears the data registers as well, so IF/ID reads as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_ADDR;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_pc4   <= '0;
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_skid_pc4   <= w_skid_pc4_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_pc4   <= w_ifid_pc4_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
    end
  end

  assign imem_req     = w_imem_req;
  assign imem_addr    = r_pc;
  assign instr_out    = r_ifid_instr;
  assign pc_out       = r_ifid_pc;
  assign pc_plus4_out = r_ifid_pc4;
  assign valid_out    = r_ifid_valid;

endmodule
